// File: rtl/tdpr_port_arbiter.sv
// rtl/tdpr_port_arbiter.sv - two-requester front end for a true dual-port RAM with same-address conflict serialisation
module tdpr_port_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int DATA_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 req_a_valid,
    output logic                 req_a_ready,
    input  logic                 req_a_we,
    input  logic [ADDR_SIZE-1:0] req_a_addr,
    input  logic [DATA_SIZE-1:0] req_a_wdata,
    output logic                 rsp_a_valid,
    output logic [DATA_SIZE-1:0] rsp_a_rdata,

    input  logic                 req_b_valid,
    output logic                 req_b_ready,
    input  logic                 req_b_we,
    input  logic [ADDR_SIZE-1:0] req_b_addr,
    input  logic [DATA_SIZE-1:0] req_b_wdata,
    output logic                 rsp_b_valid,
    output logic [DATA_SIZE-1:0] rsp_b_rdata,

    output logic                 en_a,
    output logic                 we_a,
    output logic [ADDR_SIZE-1:0] addr_a,
    output logic [DATA_SIZE-1:0] din_a,
    input  logic [DATA_SIZE-1:0] dout_a,

    output logic                 en_b,
    output logic                 we_b,
    output logic [ADDR_SIZE-1:0] addr_b,
    output logic [DATA_SIZE-1:0] din_b,
    input  logic [DATA_SIZE-1:0] dout_b,

    output logic [15:0]          conflict_cnt
);

    typedef enum logic [1:0] {
        PASS   = 2'd0,
        HOLD_A = 2'd1,
        HOLD_B = 2'd2
    } state_t;

    state_t state_q, state_d;

    // ptr_q = 0: requester a wins the next conflict, 1: requester b wins
    logic ptr_q, ptr_d;
    logic conflict;

    logic                 hold_valid_q, hold_we_q;
    logic [ADDR_SIZE-1:0] hold_addr_q;
    logic [DATA_SIZE-1:0] hold_din_q;
    logic                 hold_load, hold_we_d;
    logic [ADDR_SIZE-1:0] hold_addr_d;
    logic [DATA_SIZE-1:0] hold_din_d;

    logic                 iss_a, iss_a_we, iss_b, iss_b_we;
    logic [ADDR_SIZE-1:0] iss_a_addr, iss_b_addr;
    logic [DATA_SIZE-1:0] iss_a_din, iss_b_din;

    logic rd_a_q, rd_b_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PASS;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        conflict    = 1'b0;
        req_a_ready = (state_q == PASS);
        req_b_ready = (state_q == PASS);
        iss_a       = 1'b0;
        iss_a_we    = req_a_we;
        iss_a_addr  = req_a_addr;
        iss_a_din   = req_a_wdata;
        iss_b       = 1'b0;
        iss_b_we    = req_b_we;
        iss_b_addr  = req_b_addr;
        iss_b_din   = req_b_wdata;
        hold_load   = 1'b0;
        hold_we_d   = req_b_we;
        hold_addr_d = req_b_addr;
        hold_din_d  = req_b_wdata;

        case (state_q)
            PASS: begin
                conflict = req_a_valid && req_b_valid &&
                           (req_a_addr == req_b_addr) && (req_a_we || req_b_we);
                if (conflict) begin
                    hold_load = 1'b1;
                    ptr_d     = ~ptr_q;
                    if (!ptr_q) begin
                        iss_a   = 1'b1;
                        state_d = HOLD_B;
                    end else begin
                        iss_b       = 1'b1;
                        hold_we_d   = req_a_we;
                        hold_addr_d = req_a_addr;
                        hold_din_d  = req_a_wdata;
                        state_d     = HOLD_A;
                    end
                end else begin
                    iss_a = req_a_valid;
                    iss_b = req_b_valid;
                end
            end
            HOLD_A: begin
                iss_a      = hold_valid_q;
                iss_a_we   = hold_we_q;
                iss_a_addr = hold_addr_q;
                iss_a_din  = hold_din_q;
                state_d    = PASS;
            end
            HOLD_B: begin
                iss_b      = hold_valid_q;
                iss_b_we   = hold_we_q;
                iss_b_addr = hold_addr_q;
                iss_b_din  = hold_din_q;
                state_d    = PASS;
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q        <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_we_q    <= 1'b0;
            hold_addr_q  <= '0;
            hold_din_q   <= '0;
            en_a         <= 1'b0;
            we_a         <= 1'b0;
            addr_a       <= '0;
            din_a        <= '0;
            en_b         <= 1'b0;
            we_b         <= 1'b0;
            addr_b       <= '0;
            din_b        <= '0;
            rd_a_q       <= 1'b0;
            rd_b_q       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (hold_load) begin
                hold_valid_q <= 1'b1;
                hold_we_q    <= hold_we_d;
                hold_addr_q  <= hold_addr_d;
                hold_din_q   <= hold_din_d;
            end else if (state_q != PASS) begin
                hold_valid_q <= 1'b0;
            end

            // idle ports keep addr/din so the RAM pins do not toggle needlessly
            en_a <= iss_a;
            we_a <= iss_a && iss_a_we;
            if (iss_a) begin
                addr_a <= iss_a_addr;
                din_a  <= iss_a_din;
            end
            en_b <= iss_b;
            we_b <= iss_b && iss_b_we;
            if (iss_b) begin
                addr_b <= iss_b_addr;
                din_b  <= iss_b_din;
            end

            rd_a_q <= en_a && !we_a;
            rd_b_q <= en_b && !we_b;

            if (conflict && (conflict_cnt != 16'hFFFF)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    // RAM read data is valid the cycle after en, so it is forwarded unregistered
    assign rsp_a_valid = rd_a_q;
    assign rsp_b_valid = rd_b_q;
    assign rsp_a_rdata = rd_a_q ? dout_a : '0;
    assign rsp_b_rdata = rd_b_q ? dout_b : '0;

endmodule
